// File: rtl/uart_rx_fsm.sv
// UART receive framing controller: start detection, bit timebase,
// LSB-first deserialisation, parity/stop checking and byte strobe.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  fast_clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [5:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  tick;

    // Bit boundary: the sampler's vote is consumed on the last edge of the bit.
    assign tick        = (edge_cnt == Prescale - 6'd1);
    assign dat_samp_en = (state != IDLE);

    always_ff @(posedge fast_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == IDLE) begin
                edge_cnt <= '0;
                if (!RX_IN) begin
                    // The detection cycle itself counts as edge 0 of the start bit.
                    state     <= START;
                    edge_cnt  <= 6'd1;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    par_err   <= 1'b0;
                    stp_err   <= 1'b0;
                    bit_cnt   <= '0;
                end
            end else begin
                edge_cnt <= tick ? 6'd0 : edge_cnt + 6'd1;
                if (tick) begin
                    case (state)
                        START: begin
                            state <= sampled_bit ? IDLE : DATA;
                        end
                        DATA: begin
                            shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CW'(DATA_WIDTH - 1))
                                state <= par_en_q ? PARITY : STOP;
                        end
                        PARITY: begin
                            par_err <= (sampled_bit != (^shreg ^ par_typ_q));
                            state   <= STOP;
                        end
                        STOP: begin
                            stp_err <= ~sampled_bit;
                            if (sampled_bit && !par_err) begin
                                P_DATA     <= shreg;
                                data_valid <= 1'b1;
                            end
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: emulates the 3-vote sampler and checks frames
// against a frame-level model of the receiver's expected behaviour.
module tb_uart_rx_fsm;

    logic       fast_clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .fast_clk   (fast_clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .sampled_bit(sampled_bit),
        .dat_samp_en(dat_samp_en),
        .edge_cnt   (edge_cnt),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 fast_clk = ~fast_clk;

    int cyc = 0;
    always @(posedge fast_clk) cyc <= cyc + 1;

    // Majority-vote sampler emulation
    logic v0 = 1'b1, v1 = 1'b1, v2 = 1'b1;
    always @(posedge fast_clk) begin
        if (dat_samp_en) begin
            if (edge_cnt == Prescale / 2 - 1) v0 <= RX_IN;
            if (edge_cnt == Prescale / 2)     v1 <= RX_IN;
            if (edge_cnt == Prescale / 2 + 1) v2 <= RX_IN;
        end
    end
    assign sampled_bit = (v0 & v1) | (v0 & v2) | (v1 & v2);

    int         strobe_cyc[$];
    logic [7:0] strobe_dat[$];
    int         par_rise = -1;
    int         stp_rise = -1;
    logic       par_q = 1'b0;
    logic       stp_q = 1'b0;
    always @(negedge fast_clk) begin
        if (data_valid) begin
            strobe_cyc.push_back(cyc);
            strobe_dat.push_back(P_DATA);
        end
        if (par_err && !par_q) par_rise = cyc;
        if (stp_err && !stp_q) stp_rise = cyc;
        par_q = par_err;
        stp_q = stp_err;
    end

    int         n_chk = 0;
    int         n_fail = 0;
    int         t0 = 0;
    logic [7:0] last_good = 8'h00;

    task automatic idle(input int n);
        repeat (n) @(posedge fast_clk);
        #1;
    endtask

    task automatic bit_period(input logic b);
        RX_IN = b;
        repeat (int'(Prescale)) @(posedge fast_clk);
        #1;
    endtask

    // Drives a whole frame; returns one step into cycle t0+N*P.
    task automatic send_frame(input logic [7:0] d, input logic pb,
                              input logic sb, input logic pen,
                              input logic typ);
        PAR_EN  = pen;
        PAR_TYP = typ;
        t0 = cyc;
        bit_period(1'b0);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        for (int i = 0; i < 8; i++) bit_period(d[i]);
        if (pen) bit_period(pb);
        bit_period(sb);
    endtask

    task automatic test_reset();
        idle(3);
        n_chk++;
        if ({dat_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0",
                     {dat_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err});
        end
        rst = 1'b1;
        idle(3);
        n_chk++;
        if ({dat_samp_en, edge_cnt} !== 7'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h want 0", {dat_samp_en, edge_cnt});
        end
    endtask

    task automatic test_no_parity();
        int sc;
        Prescale = 6'd8;
        sc = strobe_cyc.size();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge fast_clk);
        n_chk++;
        if ({data_valid, P_DATA, par_err, stp_err} !== {1'b1, 8'hA5, 2'b00}) begin
            n_fail++;
            $display("FAIL a5_frame: got dv=%b d=%h pe=%b se=%b want 1 a5 0 0",
                     data_valid, P_DATA, par_err, stp_err);
        end
        last_good = 8'hA5;
        RX_IN = 1'b1;
        idle(4);
        n_chk++;
        if (strobe_cyc.size() != sc + 1 || strobe_cyc[$] - t0 != 80) begin
            n_fail++;
            $display("FAIL a5_strobe: got n=%0d off=%0d want n=%0d off=80",
                     strobe_cyc.size() - sc, strobe_cyc[$] - t0, 1);
        end
    endtask

    task automatic test_parity();
        int sc;
        Prescale = 6'd16;
        sc = strobe_cyc.size();
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge fast_clk);
        RX_IN = 1'b1;
        idle(4);
        n_chk++;
        if (strobe_cyc.size() != sc + 1 || strobe_cyc[$] - t0 != 176 ||
            P_DATA !== 8'h3C) begin
            n_fail++;
            $display("FAIL even_par_good: got n=%0d off=%0d d=%h want 1 176 3c",
                     strobe_cyc.size() - sc, strobe_cyc[$] - t0, P_DATA);
        end
        last_good = 8'h3C;
        sc = strobe_cyc.size();
        par_rise = -1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge fast_clk);
        n_chk++;
        if ({par_err, stp_err, data_valid, P_DATA} !== {3'b100, 8'h3C}) begin
            n_fail++;
            $display("FAIL even_par_bad: got pe=%b se=%b dv=%b d=%h want 1 0 0 3c",
                     par_err, stp_err, data_valid, P_DATA);
        end
        RX_IN = 1'b1;
        idle(4);
        n_chk++;
        if (par_rise - t0 != 160 || strobe_cyc.size() != sc) begin
            n_fail++;
            $display("FAIL par_err_timing: got off=%0d n=%0d want 160 0",
                     par_rise - t0, strobe_cyc.size() - sc);
        end
    endtask

    task automatic test_stop_err();
        int sc;
        Prescale = 6'd8;
        sc = strobe_cyc.size();
        stp_rise = -1;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge fast_clk);
        n_chk++;
        if ({stp_err, par_err, data_valid, P_DATA} !== {3'b100, last_good}) begin
            n_fail++;
            $display("FAIL stop_err: got se=%b pe=%b dv=%b d=%h want 1 0 0 %h",
                     stp_err, par_err, data_valid, P_DATA, last_good);
        end
        RX_IN = 1'b1;
        idle(4);
        n_chk++;
        if (stp_rise - t0 != 88 || strobe_cyc.size() != sc) begin
            n_fail++;
            $display("FAIL stp_err_timing: got off=%0d n=%0d want 88 0",
                     stp_rise - t0, strobe_cyc.size() - sc);
        end
    endtask

    task automatic test_glitch();
        int sc;
        Prescale = 6'd8;
        sc = strobe_cyc.size();
        t0 = cyc;
        RX_IN = 1'b0;
        idle(2);
        RX_IN = 1'b1;
        idle(5);
        n_chk++;
        if ({dat_samp_en, edge_cnt} !== {1'b1, 6'd7}) begin
            n_fail++;
            $display("FAIL glitch_start: got en=%b ec=%0d want 1 7", dat_samp_en, edge_cnt);
        end
        idle(1);
        n_chk++;
        if ({dat_samp_en, edge_cnt, par_err, stp_err} !== 9'h0) begin
            n_fail++;
            $display("FAIL glitch_idle: got en=%b ec=%0d pe=%b se=%b want 0",
                     dat_samp_en, edge_cnt, par_err, stp_err);
        end
        idle(20);
        n_chk++;
        if (strobe_cyc.size() != sc || dat_samp_en !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_quiet: got n=%0d en=%b want 0 0",
                     strobe_cyc.size() - sc, dat_samp_en);
        end
    endtask

    task automatic test_back_to_back();
        int sc;
        Prescale = 6'd32;
        sc = strobe_cyc.size();
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        RX_IN = 1'b1;
        idle(4);
        last_good = 8'hFF;
        n_chk++;
        if (strobe_cyc.size() != sc + 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 2", strobe_cyc.size() - sc);
        end else begin
            n_chk++;
            if (strobe_cyc[sc + 1] - strobe_cyc[sc] != 320 ||
                strobe_dat[sc] !== 8'h55 || strobe_dat[sc + 1] !== 8'hFF) begin
                n_fail++;
                $display("FAIL b2b_data: got gap=%0d d=%h,%h want 320 55,ff",
                         strobe_cyc[sc + 1] - strobe_cyc[sc],
                         strobe_dat[sc], strobe_dat[sc + 1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int sc;
        logic [7:0] d;
        Prescale = 6'd8;
        d = 8'hC3;
        PAR_EN = 1'b0;
        t0 = cyc;
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(d[i]);
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if ({dat_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err} !== 18'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want 0",
                     {dat_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err});
        end
        last_good = 8'h00;
        RX_IN = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(2);
        sc = strobe_cyc.size();
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge fast_clk);
        n_chk++;
        if ({data_valid, P_DATA, par_err, stp_err} !== {1'b1, 8'h81, 2'b00}) begin
            n_fail++;
            $display("FAIL post_reset_frame: got dv=%b d=%h pe=%b se=%b want 1 81 0 0",
                     data_valid, P_DATA, par_err, stp_err);
        end
        last_good = 8'h81;
        RX_IN = 1'b1;
        idle(4);
        n_chk++;
        if (strobe_cyc.size() != sc + 1 || strobe_cyc[$] - t0 != 80) begin
            n_fail++;
            $display("FAIL post_reset_strobe: got n=%0d off=%0d want 1 80",
                     strobe_cyc.size() - sc, strobe_cyc[$] - t0);
        end
    endtask

    task automatic test_random();
        int         sc, p, n;
        logic [7:0] d;
        logic       pen, typ, pb, sb, perr, good;
        for (int k = 0; k < 40; k++) begin
            p = 8 << $urandom_range(2);
            Prescale = 6'(p);
            d   = 8'($urandom);
            pen = 1'($urandom);
            typ = 1'($urandom);
            pb  = (^d) ^ typ;
            if ($urandom_range(3) == 0) pb = ~pb;
            sb  = ($urandom_range(6) != 0);
            perr = pen && (pb != ((^d) ^ typ));
            good = sb && !perr;
            n    = pen ? 11 : 10;
            sc = strobe_cyc.size();
            send_frame(d, pb, sb, pen, typ);
            if (good) last_good = d;
            @(negedge fast_clk);
            n_chk++;
            if ({data_valid, par_err, stp_err, P_DATA} !== {good, perr, ~sb, last_good}) begin
                n_fail++;
                $display("FAIL rand_frame %0d: got dv=%b pe=%b se=%b d=%h want %b %b %b %h",
                         k, data_valid, par_err, stp_err, P_DATA,
                         good, perr, ~sb, last_good);
            end
            RX_IN = 1'b1;
            idle($urandom_range(5, 1));
            n_chk++;
            if (strobe_cyc.size() != sc + int'(good) ||
                (good && strobe_cyc[$] - t0 != n * p)) begin
                n_fail++;
                $display("FAIL rand_strobe %0d: got n=%0d off=%0d want %0d %0d",
                         k, strobe_cyc.size() - sc, strobe_cyc[$] - t0,
                         int'(good), n * p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
